imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader that writes the instruction memory, replacing the bench-only hex preload; the CPU's instruction fetch port is the reader of the same memory.
- Receives a length-prefixed little-endian byte stream, for example from a UART receiver. Assembles 32-bit words, writes them to consecutive word addresses, then releases the CPU from reset.
- Sits between the debug/UART front end and instr_mem, and drives the cpu resetn.

Parameters:
- DEPTH, 1024, instruction memory capacity in 32-bit words.
- ADDR_W, 32, width of imem_addr (byte address).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_ready  out  1  loader can accept a byte.
- start  in  1  single-cycle pulse; restarts loading from DONE.
- imem_wr_en  out  1  instruction memory write strobe (one cycle per word).
- imem_addr  out  ADDR_W  byte address of the word being written.
- imem_wr_data  out  32  word being written.
- cpu_resetn  out  1  active-low reset to the CPU; 0 while loading.
- busy  out  1  load in progress.
- done  out  1  load finished (sticky until start or reset).
- error  out  1  length overflow or checksum failure (sticky until start or reset).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state = LEN0.
  - imem_wr_en = 0, imem_addr = BASE_ADDR, imem_wr_data = 0.
  - cpu_resetn = 0, busy = 1, done = 0, error = 0.
  - Byte counter and word counter = 0.
- Handshake:
  - A byte transfers on a rising clk edge where s_valid && s_ready.
  - s_ready is decoded from state: 1 in LEN0, LEN1, LOAD and CHK; 0 in WRITE and DONE.
  - s_data is sampled only on a transfer; s_valid gaps of any length are legal.
- LEN0: captures length[7:0] and goes to LEN1.
- LEN1: captures length[15:8].
  - If the full length is 0, go to DONE (or to CHK when checksum is enabled).
  - Otherwise go to LOAD.
- LOAD: each transferred byte goes into a little-endian shift register; the first byte lands in bits [7:0].
  - When the 4th byte of a word transfers, go to WRITE.
- WRITE: lasts exactly one cycle.
  - imem_wr_en = 1, imem_addr = BASE_ADDR + 4*word_idx, imem_wr_data = assembled word.
  - word_idx increments.
  - If word_idx+1 == length, go to DONE (or CHK); otherwise return to LOAD.
- Write latency: the strobe appears in the cycle immediately after the 4th byte's transfer edge.
- Write timing: imem_wr_en is registered, so the memory captures on the following edge. imem_addr and imem_wr_data hold their value outside WRITE.
- Overflow (length > DEPTH):
  - error is set when length is captured.
  - All payload bytes are still consumed, so the stream stays framed.
  - imem_wr_en is suppressed for word_idx >= DEPTH; no address wrap-around.
- DONE:
  - busy = 0, done = 1.
  - cpu_resetn = !error, registered, asserted in the same cycle done rises.
  - start = 1 returns to LEN0 on the next edge; done, error and counters clear and cpu_resetn drops to 0.
  - start is ignored in every other state.
- Reset mid-load: an asynchronous return to the reset values. A partially assembled word is discarded and never written. Words already written stay in memory.
- Stray bytes: bytes arriving in DONE are not accepted, because s_ready = 0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last payload word, state CHK accepts one byte.
  - The expected value is the 8-bit sum, mod 256, of both length bytes and all payload bytes.
  - On a mismatch, error is set; DONE then keeps cpu_resetn = 0.
- When undefined:
  - There is no CHK state or checksum logic.
  - DONE follows directly after the last WRITE, or after LEN1 when length = 0.

Test Plan:
- Two-word load, checksum disabled:
  - Stimulus: bytes 02 00 13 05 F0 7F 93 05 00 80.
  - Required response: exactly two imem_wr_en pulses with (0x0, 0x7FF00513) and (0x4, 0x80000593).
  - Then done = 1, cpu_resetn = 1, busy = 0, s_ready = 0.
- Backpressure and gaps:
  - Stimulus: the same stream with s_valid deasserted for 3 cycles between every byte.
  - Required response: identical writes; each strobe occurs 1 cycle after the 4th byte's transfer.
- Zero length:
  - Stimulus: bytes 00 00.
  - Required response: no imem_wr_en; done = 1 and cpu_resetn = 1 two cycles after the first byte.
- Overflow with DEPTH = 4:
  - Stimulus: length 05 00 followed by 20 payload bytes.
  - Required response: exactly 4 writes to addresses 0x0–0xC, no write to 0x10, all 22 bytes accepted.
  - Then error = 1, done = 1, cpu_resetn = 0.
- Reset mid-load:
  - Stimulus: after length 02 00 and 6 payload bytes, pulse reset asynchronously (between clock edges).
  - Required response: outputs immediately take their reset values, with 1 word written, no write for the partial word, and state LEN0.
  - A new full stream then loads correctly.
- Start reload plus checksum (IMEM_LOADER_CHECKSUM_EN defined):
  - Stimulus: from DONE, pulse start, then send 01 00 01 00 00 00 02 (sum = 0x02).
  - Required response: cpu_resetn drops to 0 on start, then after the load done = 1, error = 0, cpu_resetn = 1.
  - Repeat with trailing byte 03: required response is error = 1 and cpu_resetn = 0.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: length-prefixed little-endian words into instruction memory, then CPU release.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int                DEPTH     = 1024,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              start,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] ST_LEN0  = 3'd0;
  localparam logic [2:0] ST_LEN1  = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK   = 3'd5;
  localparam logic [2:0] ST_TAIL  = ST_CHK;
`else
  localparam logic [2:0] ST_TAIL  = ST_DONE;
`endif
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [2:0]  state, state_n;
  logic        error_n;
  logic [15:0] length;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic        xfer;
  logic [15:0] len_full;
  logic [31:0] word_full;
  logic        in_range;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
  assign s_ready = (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_LOAD) || (state == ST_CHK);
`else
  assign s_ready = (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_LOAD);
`endif

  assign xfer      = s_valid && s_ready;
  assign len_full  = {s_data, length[7:0]};
  assign word_full = {s_data, shift};
  assign in_range  = {16'd0, word_idx} < DEPTH_U;
  assign busy      = (state != ST_DONE);
  assign done      = (state == ST_DONE);

  always_comb begin
    state_n = state;
    error_n = error;
    case (state)
      ST_LEN0: if (xfer) state_n = ST_LEN1;
      ST_LEN1: if (xfer) begin
        if ({16'd0, len_full} > DEPTH_U) error_n = 1'b1;
        state_n = (len_full == 16'd0) ? ST_TAIL : ST_LOAD;
      end
      ST_LOAD: if (xfer && byte_cnt == 2'd3) state_n = ST_WRITE;
      ST_WRITE: state_n = (word_idx + 16'd1 == length) ? ST_TAIL : ST_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: if (xfer) begin
        if (s_data != sum) error_n = 1'b1;
        state_n = ST_DONE;
      end
`endif
      ST_DONE: if (start) begin
        state_n = ST_LEN0;
        error_n = 1'b0;
      end
      default: state_n = ST_LEN0;
    endcase
  end

  // Overflowing words are still consumed to keep framing, but never reach the memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_LEN0;
      error        <= 1'b0;
      cpu_resetn   <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wr_data <= '0;
      length       <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
      shift        <= '0;
    end else begin
      state      <= state_n;
      error      <= error_n;
      cpu_resetn <= (state_n == ST_DONE) && !error_n;
      imem_wr_en <= 1'b0;
      case (state)
        ST_LEN0: if (xfer) length[7:0] <= s_data;
        ST_LEN1: if (xfer) length[15:8] <= s_data;
        ST_LOAD: if (xfer) begin
          shift    <= word_full[31:8];
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3 && in_range) begin
            imem_wr_en   <= 1'b1;
            imem_addr    <= BASE_ADDR + ADDR_W'({word_idx, 2'b00});
            imem_wr_data <= word_full;
          end
        end
        ST_WRITE: word_idx <= word_idx + 16'd1;
        ST_DONE: if (start) begin
          length   <= '0;
          word_idx <= '0;
          byte_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum <= '0;
    else if (state == ST_DONE && start) sum <= '0;
    else if (xfer && state != ST_CHK) sum <= sum + s_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; a second instance with DEPTH = 4 covers overflow.
// Checksum-specific steps run only when IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset, reset4, s_valid, start, sel;
  logic [7:0] s_data;

  logic s_ready, imem_wr_en, cpu_resetn, busy, done, error;
  logic [31:0] imem_addr, imem_wr_data;
  logic s_ready4, wr_en4, cpu_resetn4, busy4, done4, error4;
  logic [31:0] addr4, data4;

  logic cur_ready, cur_wr_en, cur_done, cur_error, cur_resetn, cur_busy;
  logic [31:0] cur_addr, cur_data;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int n_xfer = 0;
  int n_wr = 0;
  int xfer_cyc [0:63];
  int wr_cyc [0:15];
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  logic [7:0] stream [0:63];
  int stream_len = 0;

  imem_loader u_dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .start(start), .imem_wr_en(imem_wr_en), .imem_addr(imem_addr), .imem_wr_data(imem_wr_data),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done), .error(error)
  );

  imem_loader #(.DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset4), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready4),
    .start(start), .imem_wr_en(wr_en4), .imem_addr(addr4), .imem_wr_data(data4),
    .cpu_resetn(cpu_resetn4), .busy(busy4), .done(done4), .error(error4)
  );

  assign cur_ready  = sel ? s_ready4    : s_ready;
  assign cur_wr_en  = sel ? wr_en4      : imem_wr_en;
  assign cur_addr   = sel ? addr4       : imem_addr;
  assign cur_data   = sel ? data4       : imem_wr_data;
  assign cur_done   = sel ? done4       : done;
  assign cur_error  = sel ? error4      : error;
  assign cur_resetn = sel ? cpu_resetn4 : cpu_resetn;
  assign cur_busy   = sel ? busy4       : busy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle++;
    if (s_valid && cur_ready) begin
      if (n_xfer < 64) xfer_cyc[n_xfer] = cycle;
      n_xfer++;
    end
  end

  always @(negedge clk) begin
    if (cur_wr_en) begin
      if (n_wr < 16) begin
        wr_addr[n_wr] = cur_addr;
        wr_data[n_wr] = cur_data;
        wr_cyc[n_wr]  = cycle;
      end
      n_wr++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reset_mon();
    n_xfer = 0;
    n_wr = 0;
    for (int i = 0; i < 64; i++) xfer_cyc[i] = -2;
    for (int i = 0; i < 16; i++) begin
      wr_cyc[i] = -1;
      wr_addr[i] = 32'hFFFF_FFFF;
      wr_data[i] = 32'hFFFF_FFFF;
    end
  endtask

  task automatic push(input logic [7:0] b);
    stream[stream_len] = b;
    stream_len++;
  endtask

  task automatic finish_stream();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < stream_len; i++) s = s + stream[i];
    push(s);
`endif
  endtask

  task automatic push_two_word();
    stream_len = 0;
    push(8'h02); push(8'h00);
    push(8'h13); push(8'h05); push(8'hF0); push(8'h7F);
    push(8'h93); push(8'h05); push(8'h00); push(8'h80);
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    s_valid = 1'b1;
    s_data = b;
    guard = 0;
    while (!cur_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    assert (guard < 20) else begin
      failures++;
      $error("[TB] FAIL ready_timeout observed=%0d expected=<20", guard);
    end
    @(negedge clk);
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic applyStimulus(input int gap);
    for (int i = 0; i < stream_len; i++) send_byte(stream[i], gap);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!cur_done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("done_timeout", 32'(guard < 40), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_two_word(input string tag);
    checkOutput({tag, "_nwr"}, n_wr, 2);
    checkOutput({tag, "_addr0"}, wr_addr[0], 32'h0000_0000);
    checkOutput({tag, "_data0"}, wr_data[0], 32'h7FF0_0513);
    checkOutput({tag, "_addr1"}, wr_addr[1], 32'h0000_0004);
    checkOutput({tag, "_data1"}, wr_data[1], 32'h8000_0593);
    checkOutput({tag, "_lat0"}, wr_cyc[0], xfer_cyc[5]);
    checkOutput({tag, "_lat1"}, wr_cyc[1], xfer_cyc[9]);
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_cpu_resetn"}, cpu_resetn, 1'b1);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_error"}, error, 1'b0);
    checkOutput({tag, "_ready"}, s_ready, 1'b0);
  endtask

  initial begin
    reset = 1'b1; reset4 = 1'b1; sel = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; start = 1'b0;
    reset_mon();
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_wr_en", imem_wr_en, 1'b0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_data", imem_wr_data, 32'h0);
    checkOutput("rst_cpu_resetn", cpu_resetn, 1'b0);
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 1'b0);
    checkOutput("rst_ready", s_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] two-word load, no gaps");
    reset_mon();
    push_two_word();
    finish_stream();
    applyStimulus(0);
    wait_done();
    check_two_word("t1");

    $display("[TB] stray bytes in DONE");
    s_valid = 1'b1; s_data = 8'hAA;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("stray_xfer", n_xfer, stream_len);
    checkOutput("stray_nwr", n_wr, 2);

    $display("[TB] start reload with gaps");
    pulse_start();
    checkOutput("start_cpu_resetn", cpu_resetn, 1'b0);
    checkOutput("start_busy", busy, 1'b1);
    checkOutput("start_done", done, 1'b0);
    reset_mon();
    push_two_word();
    finish_stream();
    applyStimulus(3);
    wait_done();
    check_two_word("t2");

    $display("[TB] zero length");
    pulse_start();
    reset_mon();
    stream_len = 0;
    push(8'h00); push(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    finish_stream();
    applyStimulus(0);
    wait_done();
`else
    applyStimulus(0);
`endif
    checkOutput("zero_done", done, 1'b1);
    checkOutput("zero_cpu_resetn", cpu_resetn, 1'b1);
    checkOutput("zero_nwr", n_wr, 0);

    $display("[TB] reset mid-load");
    pulse_start();
    reset_mon();
    stream_len = 0;
    push(8'h02); push(8'h00);
    push(8'h13); push(8'h05); push(8'hF0); push(8'h7F);
    push(8'h93); push(8'h05);
    applyStimulus(0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_wr_en", imem_wr_en, 1'b0);
    checkOutput("midrst_data", imem_wr_data, 32'h0);
    checkOutput("midrst_busy", busy, 1'b1);
    checkOutput("midrst_ready", s_ready, 1'b1);
    checkOutput("midrst_cpu_resetn", cpu_resetn, 1'b0);
    checkOutput("midrst_nwr", n_wr, 1);
    checkOutput("midrst_word0", wr_data[0], 32'h7FF0_0513);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_partial", n_wr, 1);
    reset_mon();
    push_two_word();
    finish_stream();
    applyStimulus(0);
    wait_done();
    check_two_word("t4");

    $display("[TB] overflow with DEPTH=4");
    sel = 1'b1;
    reset4 = 1'b0;
    @(negedge clk);
    reset_mon();
    stream_len = 0;
    push(8'h05); push(8'h00);
    for (int i = 0; i < 20; i++) push(8'h10 + 8'(i));
    finish_stream();
    applyStimulus(0);
    wait_done();
    checkOutput("ovf_nwr", n_wr, 4);
    checkOutput("ovf_addr0", wr_addr[0], 32'h0);
    checkOutput("ovf_data0", wr_data[0], 32'h1312_1110);
    checkOutput("ovf_addr3", wr_addr[3], 32'hC);
    checkOutput("ovf_data3", wr_data[3], 32'h1F1E_1D1C);
    checkOutput("ovf_xfer", n_xfer, stream_len);
    checkOutput("ovf_error", cur_error, 1'b1);
    checkOutput("ovf_done", cur_done, 1'b1);
    checkOutput("ovf_busy", cur_busy, 1'b0);
    checkOutput("ovf_cpu_resetn", cur_resetn, 1'b0);
    sel = 1'b0;
    reset4 = 1'b1;
    @(negedge clk);

    $display("[TB] start reload, one word");
    pulse_start();
    checkOutput("reload_cpu_resetn", cpu_resetn, 1'b0);
    reset_mon();
    stream_len = 0;
    push(8'h01); push(8'h00); push(8'h01); push(8'h00); push(8'h00); push(8'h00);
    finish_stream();
    applyStimulus(0);
    wait_done();
    checkOutput("reload_nwr", n_wr, 1);
    checkOutput("reload_data", wr_data[0], 32'h0000_0001);
    checkOutput("reload_done", done, 1'b1);
    checkOutput("reload_error", error, 1'b0);
    checkOutput("reload_cpu_resetn1", cpu_resetn, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] bad checksum");
    pulse_start();
    reset_mon();
    stream_len = 0;
    push(8'h01); push(8'h00); push(8'h01); push(8'h00); push(8'h00); push(8'h00);
    push(8'h03);
    applyStimulus(0);
    wait_done();
    checkOutput("badchk_error", error, 1'b1);
    checkOutput("badchk_cpu_resetn", cpu_resetn, 1'b0);
    checkOutput("badchk_done", done, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
